cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 138 +++++++++++++
 tb/tb_cpu_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit accumulator CPU.
// Owns the PC and instruction register, and drives the datapath strobes.
module cpu_sequencer #(
  parameter int unsigned PC_W     = 3,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            run,
  input  logic            resume,
  input  logic [3:0]      rom_data,
  input  logic            carry_in,
  output logic [PC_W-1:0] rom_addr,
  output logic [PC_W-1:0] pc_out,
  output logic            mux_sel,
  output logic [1:0]      alu_op,
  output logic            reg_we,
  output logic            carry_we,
  output logic            instr_done,
  output logic            halted,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;

  // Output vector: {mux_sel, alu_op[1:0], reg_we, carry_we, instr_done, halted}
  function automatic logic [6:0] decode_outs(input state_e st, input logic [3:0] ir);
    logic [6:0] o;
    o = 7'b000_0000;
    case (st)
      S_DECODE:  o[1] = (ir == OP_NOP);
      S_OPERAND: o[1] = 1'b1;
      S_EXECUTE: begin
        case (ir[3:2])
          2'b00:   o = 7'b1_00_1_0_1_0;
          2'b01:   o = 7'b0_01_1_1_1_0;
          2'b10:   o = 7'b0_10_1_1_1_0;
          default: o = 7'b000_0000;
        endcase
      end
      S_HALT:    o[0] = 1'b1;
      default:   o = 7'b000_0000;
    endcase
    return o;
  endfunction

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      ir_q, ir_d;
  logic [6:0]      outs_q, outs_d;
  logic [PC_W-1:0] pc_inc_s;

  assign pc_inc_s = pc_q + PC_W'(1);

  // Next-state, PC and IR sequencing
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          pc_d    = pc_inc_s;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (ir_q[3:2] != 2'b11) begin
          state_d = S_EXECUTE;
        end else if (ir_q == OP_NOP) begin
          state_d = S_FETCH;
        end else if (ir_q == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_OPERAND;
        end
      end
      S_OPERAND: begin
        // pc points at the operand word; a not-taken JC skips over it
        if (ir_q == OP_JMP || carry_in) begin
          pc_d = rom_data[PC_W-1:0];
        end else begin
          pc_d = pc_inc_s;
        end
        state_d = S_FETCH;
      end
      S_EXECUTE: state_d = S_FETCH;
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_FETCH;
    endcase
    outs_d = decode_outs(state_d, ir_d);
  end

  // State registers; outputs are registered from the decoded next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= 4'b0000;
      outs_q  <= 7'b000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      outs_q  <= outs_d;
    end
  end

  assign rom_addr   = pc_q;
  assign pc_out     = pc_q;
  assign state_out  = state_q;
  assign mux_sel    = outs_q[6];
  assign alu_op     = outs_q[5:4];
  assign reg_we     = outs_q[3];
  assign carry_we   = outs_q[2];
  assign instr_done = outs_q[1];
  assign halted     = outs_q[0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle checks of state, PC and strobes.
module tb_cpu_sequencer;

  logic       clk, rstn, run, resume, carry_in;
  logic [3:0] rom_data;
  logic [2:0] rom_addr, pc_out, state_out;
  logic       mux_sel, reg_we, carry_we, instr_done, halted;
  logic [1:0] alu_op;
  logic [3:0] rom [0:7];
  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.PC_W(3), .RESET_PC(0)) dut (
    .clk(clk), .rstn(rstn), .run(run), .resume(resume), .rom_data(rom_data),
    .carry_in(carry_in), .rom_addr(rom_addr), .pc_out(pc_out), .mux_sel(mux_sel),
    .alu_op(alu_op), .reg_we(reg_we), .carry_we(carry_we), .instr_done(instr_done),
    .halted(halted), .state_out(state_out)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc, mux_sel, alu_op, reg_we, carry_we, instr_done, halted}
  function automatic logic [12:0] obs();
    return {state_out, pc_out, mux_sel, alu_op, reg_we, carry_we, instr_done, halted};
  endfunction

  function automatic logic [12:0] ex(input int st, input int pc, input bit mx, input int alu,
                                     input bit rw, input bit cw, input bit id, input bit h);
    logic [2:0] s3, p3;
    logic [1:0] a2;
    s3 = st[2:0]; p3 = pc[2:0]; a2 = alu[1:0];
    return {s3, p3, mx, a2, rw, cw, id, h};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_program();
    rom[0] = 4'b0000; rom[1] = 4'b0101; rom[2] = 4'b1000; rom[3] = 4'b1101;
    rom[4] = 4'b1111; rom[5] = 4'b0001; rom[6] = 4'b1110; rom[7] = 4'b0011;
  endtask

  task automatic do_reset();
    rstn = 1'b0; run = 1'b0; resume = 1'b0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    do_reset();
    e = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL reset got %h exp %h", obs(), e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (obs() !== e) begin errors++; $display("FAIL reset_hold%0d got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_ldm();
    logic [12:0] e;
    run = 1'b1;
    tick(); e = ex(1, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ldm_decode got %h exp %h", obs(), e); end
    tick(); e = ex(3, 1, 1, 0, 1, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ldm_exec got %h exp %h", obs(), e); end
    tick(); e = ex(0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ldm_fetch got %h exp %h", obs(), e); end
  endtask

  task automatic test_alu();
    logic [12:0] e;
    tick(); e = ex(1, 2, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL add_decode got %h exp %h", obs(), e); end
    tick(); e = ex(3, 2, 0, 1, 1, 1, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL add_exec got %h exp %h", obs(), e); end
    tick(); tick(); e = ex(1, 3, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL sub_decode got %h exp %h", obs(), e); end
    tick(); e = ex(3, 3, 0, 2, 1, 1, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL sub_exec got %h exp %h", obs(), e); end
    tick(); e = ex(0, 3, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL sub_fetch got %h exp %h", obs(), e); end
  endtask

  task automatic test_halt();
    logic [12:0] e;
    tick(); tick(); e = ex(4, 4, 0, 0, 0, 0, 0, 1);
    checks++; if (obs() !== e) begin errors++; $display("FAIL halt_enter got %h exp %h", obs(), e); end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (obs() !== e) begin errors++; $display("FAIL halt_hold%0d got %h exp %h", i, obs(), e); end
    end
    resume = 1'b1; tick(); resume = 1'b0;
    e = ex(0, 4, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL halt_resume got %h exp %h", obs(), e); end
    resume = 1'b1; tick(); resume = 1'b0;
    checks++; if (obs() !== e) begin errors++; $display("FAIL resume_ignored got %h exp %h", obs(), e); end
  endtask

  task automatic test_jc_not_taken_then_jmp();
    logic [12:0] e;
    carry_in = 1'b0; run = 1'b1;
    tick(); tick(); e = ex(2, 5, 0, 0, 0, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jcn_operand got %h exp %h", obs(), e); end
    tick(); e = ex(0, 6, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jcn_pc got %h exp %h", obs(), e); end
    tick(); e = ex(1, 7, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jmp_decode got %h exp %h", obs(), e); end
    run = 1'b0;
    tick(); e = ex(2, 7, 0, 0, 0, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jmp_operand got %h exp %h", obs(), e); end
    e = ex(0, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs() !== e) begin errors++; $display("FAIL jmp_stall%0d got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_jc_taken();
    logic [12:0] e;
    do_reset();
    rom[0] = 4'b1110; rom[1] = 4'b0100;
    run = 1'b1;
    tick(); tick(); tick(); e = ex(0, 4, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jmp4_pc got %h exp %h", obs(), e); end
    carry_in = 1'b1;
    tick(); tick(); e = ex(2, 5, 0, 0, 0, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jct_operand got %h exp %h", obs(), e); end
    run = 1'b0;
    e = ex(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs() !== e) begin errors++; $display("FAIL jct_pc%0d got %h exp %h", i, obs(), e); end
    end
    carry_in = 1'b0;
    load_program();
  endtask

  task automatic test_nop_wrap();
    logic [12:0] e;
    do_reset();
    rom[0] = 4'b1110; rom[1] = 4'b0111; rom[7] = 4'b1100;
    run = 1'b1;
    tick(); tick(); tick(); e = ex(0, 7, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL jmp7_pc got %h exp %h", obs(), e); end
    tick(); e = ex(1, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL nop_wrap got %h exp %h", obs(), e); end
    run = 1'b0;
    tick(); e = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL nop_retire got %h exp %h", obs(), e); end
    load_program();
  endtask

  task automatic test_reset_mid_exec();
    logic [12:0] e;
    do_reset();
    run = 1'b1;
    tick(); tick(); e = ex(3, 1, 1, 0, 1, 0, 1, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL pre_reset_exec got %h exp %h", obs(), e); end
    #2 rstn = 1'b0;
    #1 e = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL async_reset got %h exp %h", obs(), e); end
    run = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  initial begin
    load_program();
    test_reset();
    test_ldm();
    test_alu();
    test_halt();
    test_jc_not_taken_then_jmp();
    test_jc_taken();
    test_nop_wrap();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
